reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- MIPS general-purpose register file: the consumer of the writeback stage's write port.
- Provides 32x32 storage, with $zero hardwired to 0.
- Provides two combinational read ports for decode, with same-cycle write-to-read bypass.
- Includes a per-register busy scoreboard so decode can stall on registers owned by in-flight multi-cycle producers (loads, mul/div), including the link register written for branch-and-link.

Parameters:
- NREG, 32, number of architectural registers (fixed at 32; index width 5).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  write enable from writeback.
- wb_dest  in  5  write register index.
- wb_data  in  32  write data.
- rs_addr  in  5  read port A index.
- rt_addr  in  5  read port B index.
- rs_data  out  32  read port A data.
- rt_data  out  32  read port B data.
- rs_busy  out  1  port A register has an outstanding producer.
- rt_busy  out  1  port B register has an outstanding producer.
- issue_en  in  1  decode issues an instruction that will later write issue_dest.
- issue_dest  in  5  destination claimed at issue.
- flush  in  1  pipeline flush; clears all busy bits.
- stall_out  out  1  (rs_busy | rt_busy) & read_req.
- read_req  in  1  decode currently needs rs/rt.

Behaviour:
- Clocking: one clock (clk); reset is synchronous, active-high (rst).
- Reset:
  - On the rst edge, all 32 registers become 0 and all busy bits become 0.
  - Outputs follow combinationally: rs_data = rt_data = 0, rs_busy = rt_busy = 0, stall_out = 0.
  - rst has priority over wb_en, issue_en and flush in the same cycle.
- Write:
  - On a clk edge with wb_en = 1 and wb_dest != 0, regs[wb_dest] <= wb_data.
  - Writes to index 0 are discarded; regs[0] reads 0 always.
- Read:
  - Combinational, zero latency: rs_data = (rs_addr == 0) ? 0 : regs[rs_addr].
  - Bypass: if wb_en & wb_dest == rs_addr & rs_addr != 0, rs_data = wb_data in the same cycle.
  - Port B (rt) behaves identically.
- Scoreboard, busy[31:0], with busy[0] tied to 0:
  - issue_en with issue_dest != 0 sets busy[issue_dest] on the edge.
  - wb_en with wb_dest != 0 clears busy[wb_dest] on the edge.
  - Same register set and cleared in the same cycle: set wins (the new producer owns it).
  - Different registers: both updates apply.
  - flush clears all busy bits. If issue_en coincides with flush, the issue still sets its bit (the issuing instruction is post-flush).
- Busy outputs:
  - rs_busy = busy[rs_addr] & ~(wb_en & wb_dest == rs_addr).
  - A writeback in the current cycle masks busy because the bypass delivers the data; rt_busy is analogous.
  - Index 0 is never busy.
- Writes to non-busy registers are legal (single-cycle producers do not use the scoreboard); they update storage and leave the busy bit 0.
- Multiple issues to the same busy register: the bit stays 1 and is cleared by the first matching writeback. In-order writeback is guaranteed upstream.
- No handshake beyond stall_out: decode holds rs/rt and issue_en low while stall_out = 1.

Decomposition:
- Shared package (cpu_pkg):
  - typedef reg_idx_t (logic [4:0]) and word_t (logic [31:0]).
  - Constants REG_ZERO = 5'd0 and REG_RA = 5'd31 (link target).
- One natural sub-module, reg_scoreboard: busy vector, set/clear/flush priority, busy lookups.
- The storage array, bypass muxes and stall logic stay in the top module.

Test Plan:
- Reset then read all indices -> every rs_data/rt_data = 0, busy = 0; write 0xDEADBEEF to r0, then read r0 -> 0.
- Write r5 = 0x12345678 with rs_addr = 5 in the same cycle -> rs_data = 0x12345678 combinationally (bypass); next cycle, wb_en = 0 -> still 0x12345678 from storage.
- issue_en with dest 31 -> next cycle rt_addr = 31 gives rt_busy = 1, and with read_req = 1 stall_out = 1; wb_en to 31 with data 0x00400008 -> same cycle rt_busy = 0, rt_data = 0x00400008.
- Same cycle, issue_en dest 7 and wb_en dest 7 -> next cycle busy[7] = 1, regs[7] = wb_data.
- Set busy on r3, r4, r9, then flush (with simultaneous issue_en dest 10) -> only busy[10] = 1 afterwards; register contents unchanged.
- Write r8 = 0xA5A5A5A5, set busy on r8, then assert rst with wb_en to r8 -> next cycle regs[8] = 0, busy[8] = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and register-index constants used by the register file slice.
package cpu_pkg;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register marking an outstanding multi-cycle producer.
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     clr_en,
   input  reg_idx_t clr_idx,
   input  logic     flush,
   input  reg_idx_t rs_idx,
   input  reg_idx_t rt_idx,
   output logic     rs_busy,
   output logic     rt_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   // Flush or writeback clears first so that a same-cycle issue always ends up owning its register.
   always_comb begin
      busy_next = busy;
      if (flush) begin
         busy_next = '0;
      end else if (clr_en && clr_idx != REG_ZERO) begin
         busy_next[clr_idx] = 1'b0;
      end
      if (set_en && set_idx != REG_ZERO) begin
         busy_next[set_idx] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Busy vector register; reset wins over every update.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // A writeback landing this cycle hides busy because the bypass already supplies the value.
   always_comb begin
      rs_busy = busy[rs_idx] & ~(clr_en && clr_idx == rs_idx);
      rt_busy = busy[rt_idx] & ~(clr_en && clr_idx == rt_idx);
   end

endmodule

// File: rtl/reg_file_sb.sv
// MIPS GPR file: 32x32 storage, two bypassed read ports and a busy scoreboard for decode stalls.
module reg_file_sb
   import cpu_pkg::*;
#(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_en,
   input  reg_idx_t      wb_dest,
   input  logic [DW-1:0] wb_data,
   input  reg_idx_t      rs_addr,
   input  reg_idx_t      rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   output logic          rs_busy,
   output logic          rt_busy,
   input  logic          issue_en,
   input  reg_idx_t      issue_dest,
   input  logic          flush,
   output logic          stall_out,
   input  logic          read_req
);

   logic [DW-1:0] regs [NREG];

   // Register storage; writes to $zero are dropped so it always holds zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && wb_dest != REG_ZERO) begin
         regs[wb_dest] <= wb_data;
      end
   end

   // Read ports: $zero reads 0, a same-cycle writeback is forwarded, otherwise storage.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs_addr != REG_ZERO) begin
         rs_data = (wb_en && wb_dest == rs_addr) ? wb_data : regs[rs_addr];
      end
      if (rt_addr != REG_ZERO) begin
         rt_data = (wb_en && wb_dest == rt_addr) ? wb_data : regs[rt_addr];
      end
   end

   reg_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (issue_en),
      .set_idx (issue_dest),
      .clr_en  (wb_en),
      .clr_idx (wb_dest),
      .flush   (flush),
      .rs_idx  (rs_addr),
      .rt_idx  (rt_addr),
      .rs_busy (rs_busy),
      .rt_busy (rt_busy)
   );

   // Decode stalls only when it actually needs an operand that is still being produced.
   always_comb begin
      stall_out = (rs_busy | rt_busy) & read_req;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_sb;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   reg_idx_t    wb_dest;
   logic [31:0] wb_data;
   reg_idx_t    rs_addr;
   reg_idx_t    rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rs_busy;
   logic        rt_busy;
   logic        issue_en;
   reg_idx_t    issue_dest;
   logic        flush;
   logic        stall_out;
   logic        read_req;

   int testCount = 0;
   int failCount = 0;

   logic [31:0] modelRegs [32];
   bit          modelBusy [32];

   reg_file_sb #(.NREG(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_en      (wb_en),
      .wb_dest    (wb_dest),
      .wb_data    (wb_data),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .rs_busy    (rs_busy),
      .rt_busy    (rt_busy),
      .issue_en   (issue_en),
      .issue_dest (issue_dest),
      .flush      (flush),
      .stall_out  (stall_out),
      .read_req   (read_req)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] expectRead(input reg_idx_t addr);
      if (addr == 5'd0) return 32'd0;
      if (wb_en && wb_dest == addr) return wb_data;
      return modelRegs[addr];
   endfunction

   function automatic logic expectBusy(input reg_idx_t addr);
      if (addr == 5'd0) return 1'b0;
      if (wb_en && wb_dest == addr) return 1'b0;
      return modelBusy[addr];
   endfunction

   // Drive one cycle of inputs, check combinational outputs mid-cycle, then advance the model on the edge.
   task automatic applyStimulus(input logic r, input logic we, input reg_idx_t wd, input logic [31:0] wdat,
                                input reg_idx_t ra, input reg_idx_t rb, input logic ie, input reg_idx_t id,
                                input logic fl, input logic rq);
      logic expRsBusy;
      logic expRtBusy;
      rst = r; wb_en = we; wb_dest = wd; wb_data = wdat;
      rs_addr = ra; rt_addr = rb; issue_en = ie; issue_dest = id;
      flush = fl; read_req = rq;
      #4;
      if (!r) begin
         expRsBusy = expectBusy(ra);
         expRtBusy = expectBusy(rb);
         checkOutput($sformatf("rs_data[r%0d]", ra), rs_data, expectRead(ra));
         checkOutput($sformatf("rt_data[r%0d]", rb), rt_data, expectRead(rb));
         checkOutput($sformatf("rs_busy[r%0d]", ra), 32'(rs_busy), 32'(expRsBusy));
         checkOutput($sformatf("rt_busy[r%0d]", rb), 32'(rt_busy), 32'(expRtBusy));
         checkOutput("stall_out", 32'(stall_out), 32'((expRsBusy | expRtBusy) & rq));
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) begin
            modelRegs[i] = 32'd0;
            modelBusy[i] = 1'b0;
         end
      end else begin
         if (we && wd != 5'd0) modelRegs[wd] = wdat;
         if (fl) begin
            for (int i = 0; i < 32; i++) modelBusy[i] = 1'b0;
         end else if (we && wd != 5'd0) begin
            modelBusy[wd] = 1'b0;
         end
         if (ie && id != 5'd0) modelBusy[id] = 1'b1;
      end
      #1;
   endtask

   task automatic readOnly(input reg_idx_t ra, input reg_idx_t rb);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, ra, rb, 1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   function automatic reg_idx_t pickIdx();
      int v;
      v = int'($urandom_range(0, 9));
      return (v == 9) ? REG_RA : reg_idx_t'(v);
   endfunction

   initial begin
      rst = 1'b1; wb_en = 1'b0; wb_dest = '0; wb_data = '0;
      rs_addr = '0; rt_addr = '0; issue_en = 1'b0; issue_dest = '0;
      flush = 1'b0; read_req = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         modelRegs[i] = 32'd0;
         modelBusy[i] = 1'b0;
      end

      // Reset state across every index, then a discarded write to $zero.
      for (int i = 0; i < 32; i++) readOnly(reg_idx_t'(i), reg_idx_t'(31 - i));
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      readOnly(5'd0, 5'd0);
      checkOutput("r0_after_write", rs_data, 32'd0);

      // Bypass then storage read of r5.
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      readOnly(5'd5, 5'd5);

      // Link register claimed, stalls, then writeback masks busy and bypasses data.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, REG_RA, 1'b0, 1'b0);
      readOnly(5'd0, REG_RA);
      applyStimulus(1'b0, 1'b1, REG_RA, 32'h00400008, 5'd0, REG_RA, 1'b0, 5'd0, 1'b0, 1'b1);
      readOnly(REG_RA, 5'd0);

      // Same-cycle issue and writeback to r7: set wins, data lands.
      applyStimulus(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      readOnly(5'd7, 5'd7);

      // Busy r3/r4/r9 then flush with a post-flush issue to r10.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd9, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10, 1'b1, 5'd10, 1'b1, 1'b1);
      readOnly(5'd3, 5'd4);
      readOnly(5'd9, 5'd10);
      readOnly(5'd5, 5'd7);

      // Reset beats a simultaneous writeback and an outstanding busy bit on r8.
      applyStimulus(1'b0, 1'b1, 5'd8, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
      readOnly(5'd8, 5'd8);
      applyStimulus(1'b1, 1'b1, 5'd8, 32'h11111111, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1);
      readOnly(5'd8, 5'd10);
      checkOutput("r8_after_reset", rs_data, 32'd0);

      // Randomized traffic with collisions concentrated on a few registers.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), pickIdx(), $urandom,
                       pickIdx(), pickIdx(), 1'($urandom_range(0, 1)), pickIdx(),
                       ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
